// File: rtl/frv_imem_arbiter_pkg.sv
// Shared constants and helpers for the two-requester instruction-memory arbiter.
// Holds the bus widths, the grant encodings and the burst-counter saturation rule.
package frv_imem_arbiter_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    localparam logic GNT_R0 = 1'b0;
    localparam logic GNT_R1 = 1'b1;

    // The count never exceeds max_burst-1, which is the value that forces the hand-over.
    function automatic logic [3:0] burst_sat_inc(logic [3:0] cnt, int unsigned max_burst);
        if (32'(cnt) + 32'd1 >= max_burst) begin
            return 4'(max_burst - 32'd1);
        end
        return cnt + 4'd1;
    endfunction

endpackage

// File: rtl/frv_imem_arbiter_if.sv
// Instruction-memory bus bundle: a request side (cen/wen/strb/addr/wdata) and
// a response side (stall/error/rdata).
interface frv_imem_arbiter_if;
    import frv_imem_arbiter_pkg::*;

    logic              cen;
    logic              wen;
    logic [STRB_W-1:0] strb;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic              stall;
    logic              error;
    logic [XLEN-1:0]   rdata;

    modport master (
        output cen, wen, strb, addr, wdata,
        input  stall, error, rdata
    );

    modport slave (
        input  cen, wen, strb, addr, wdata,
        output stall, error, rdata
    );

endinterface

// File: rtl/frv_arb2_pick.sv
// Combinational two-way grant pick. It uses the held owner, the active requests,
// the previous grant and the burst limit.
module frv_arb2_pick
    import frv_imem_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic       lock_i,
    input  logic       lock_owner_i,
    input  logic       burst_hit_i,
    output logic       grant_o
);

    always_comb begin
        grant_o = last_grant_i;
        if (lock_i) begin
            grant_o = lock_owner_i;
        end else if (req_i == 2'b11) begin
            grant_o = (burst_hit_i || !FIXED_PRIORITY) ? ~last_grant_i : GNT_R0;
        end else if (req_i[0]) begin
            grant_o = GNT_R0;
        end else if (req_i[1]) begin
            grant_o = GNT_R1;
        end
    end

endmodule

// File: rtl/frv_imem_arbiter.sv
// Shares one imem port between front-end fetch (R0) and a secondary master (R1).
// It arbitrates with a burst limit, holds the grant under memory stall and routes each response.
module frv_imem_arbiter
    import frv_imem_arbiter_pkg::*;
#(
    parameter bit          FIXED_PRIORITY = 1'b0,
    parameter int unsigned MAX_BURST      = 4
) (
    input  logic                g_clk,
    input  logic                g_reset,
    frv_imem_arbiter_if.slave   r0_io,
    frv_imem_arbiter_if.slave   r1_io,
    frv_imem_arbiter_if.master  m_io,
    output logic                arb_owner_o
);

    logic       last_grant_q, last_grant_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       lock_q, lock_d;
    logic       lock_owner_q, lock_owner_d;
    logic       resp_valid_q, resp_valid_d;
    logic       resp_owner_q, resp_owner_d;

    logic [1:0] req;
    logic       lock_eff;
    logic       burst_hit;
    logic       grant;
    logic       accept;

    assign req       = {r1_io.cen, r0_io.cen};
    // A held grant is released at once if its owner abandons the request.
    assign lock_eff  = lock_q & req[lock_owner_q];
    assign burst_hit = (burst_cnt_q == 4'(MAX_BURST - 32'd1));

    frv_arb2_pick #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .lock_i       (lock_eff),
        .lock_owner_i (lock_owner_q),
        .burst_hit_i  (burst_hit),
        .grant_o      (grant)
    );

    always_comb begin
        m_io.cen = req[grant];
        if (grant == GNT_R1) begin
            m_io.wen   = r1_io.wen;
            m_io.strb  = r1_io.strb;
            m_io.addr  = r1_io.addr;
            m_io.wdata = r1_io.wdata;
        end else begin
            m_io.wen   = r0_io.wen;
            m_io.strb  = r0_io.strb;
            m_io.addr  = r0_io.addr;
            m_io.wdata = r0_io.wdata;
        end
    end

    assign accept = m_io.cen & ~m_io.stall;

    assign r0_io.stall = r0_io.cen & ~((grant == GNT_R0) & ~m_io.stall);
    assign r1_io.stall = r1_io.cen & ~((grant == GNT_R1) & ~m_io.stall);

    assign r0_io.rdata = m_io.rdata;
    assign r1_io.rdata = m_io.rdata;
    assign r0_io.error = m_io.error & resp_valid_q & (resp_owner_q == GNT_R0);
    assign r1_io.error = m_io.error & resp_valid_q & (resp_owner_q == GNT_R1);

    assign arb_owner_o = g_reset ? GNT_R0 : grant;

    always_comb begin
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        lock_d       = 1'b0;
        lock_owner_d = lock_owner_q;
        resp_valid_d = accept;
        resp_owner_d = resp_owner_q;
        if (accept) begin
            last_grant_d = grant;
            resp_owner_d = grant;
            burst_cnt_d  = (grant == last_grant_q && req[~grant]) ?
                           burst_sat_inc(burst_cnt_q, MAX_BURST) : 4'd0;
        end else if (m_io.cen && m_io.stall) begin
            lock_d       = 1'b1;
            lock_owner_d = grant;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            last_grant_q <= GNT_R1;
            burst_cnt_q  <= 4'd0;
            lock_q       <= 1'b0;
            lock_owner_q <= GNT_R0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= GNT_R0;
        end else begin
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

endmodule

// File: tb/tb_frv_imem_arbiter.sv
// Randomized bench for two arbiter builds: round-robin with MAX_BURST=1 and fixed priority
// with MAX_BURST=4. Both are compared every cycle against a behavioural model.
module tb_frv_imem_arbiter;

    logic g_clk = 1'b0;
    logic g_reset;
    always #5 g_clk = ~g_clk;

    logic        cen   [2][2];
    logic        wen   [2][2];
    logic [3:0]  strb  [2][2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic        m_stall [2];
    logic        m_error [2];
    logic [31:0] m_rdata [2];

    logic        st  [2][2];
    logic        er  [2][2];
    logic [31:0] rd  [2][2];
    logic        mcen   [2];
    logic        mwen   [2];
    logic [3:0]  mstrb  [2];
    logic [31:0] maddr  [2];
    logic [31:0] mwdata [2];
    logic        own    [2];

    frv_imem_arbiter_if rif [4] ();
    frv_imem_arbiter_if mif [2] ();

    for (genvar d = 0; d < 2; d++) begin : g_dut
        for (genvar n = 0; n < 2; n++) begin : g_req
            assign rif[2*d+n].cen   = cen[d][n];
            assign rif[2*d+n].wen   = wen[d][n];
            assign rif[2*d+n].strb  = strb[d][n];
            assign rif[2*d+n].addr  = addr[d][n];
            assign rif[2*d+n].wdata = wdata[d][n];
            assign st[d][n]         = rif[2*d+n].stall;
            assign er[d][n]         = rif[2*d+n].error;
            assign rd[d][n]         = rif[2*d+n].rdata;
        end
        assign mif[d].stall = m_stall[d];
        assign mif[d].error = m_error[d];
        assign mif[d].rdata = m_rdata[d];
        assign mcen[d]      = mif[d].cen;
        assign mwen[d]      = mif[d].wen;
        assign mstrb[d]     = mif[d].strb;
        assign maddr[d]     = mif[d].addr;
        assign mwdata[d]    = mif[d].wdata;

        frv_imem_arbiter #(
            .FIXED_PRIORITY (d == 1),
            .MAX_BURST      ((d == 1) ? 32'd4 : 32'd1)
        ) u_dut (
            .g_clk       (g_clk),
            .g_reset     (g_reset),
            .r0_io       (rif[2*d]),
            .r1_io       (rif[2*d+1]),
            .m_io        (mif[d]),
            .arb_owner_o (own[d])
        );
    end

    // Reference model: held owner (-1 = none), last accepted owner, run length, pending response.
    int held      [2];
    int last_acc  [2];
    int streak    [2];
    int resp_who  [2];
    bit resp_pend [2];
    bit st_prev   [2][2];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int mb(int d);
        return (d == 1) ? 4 : 1;
    endfunction

    function automatic bit fp(int d);
        return d == 1;
    endfunction

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int exp_grant(int d);
        if (held[d] >= 0 && cen[d][held[d]]) return held[d];
        if (cen[d][0] && cen[d][1]) begin
            if (streak[d] == mb(d) - 1 || !fp(d)) return 1 - last_acc[d];
            return 0;
        end
        if (cen[d][0]) return 0;
        if (cen[d][1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            held[d] = -1; last_acc[d] = 1; streak[d] = 0;
            resp_who[d] = 0; resp_pend[d] = 1'b0;
            for (int n = 0; n < 2; n++) begin
                cen[d][n] = 1'b0; st_prev[d][n] = 1'b0;
            end
        end
    endtask

    task automatic drive(int d, int p_cen, int p_stall);
        for (int n = 0; n < 2; n++) begin
            if (cen[d][n] && st_prev[d][n]) begin
                // Stalled requester holds its fields; occasionally it abandons.
                if ($urandom_range(99) < 10) cen[d][n] = 1'b0;
            end else begin
                cen[d][n]   = ($urandom_range(99) < p_cen);
                wen[d][n]   = 1'($urandom);
                strb[d][n]  = 4'($urandom);
                addr[d][n]  = $urandom;
                wdata[d][n] = $urandom;
            end
        end
        m_stall[d] = ($urandom_range(99) < p_stall);
        m_error[d] = 1'($urandom);
        m_rdata[d] = $urandom;
    endtask

    task automatic check_cycle(int d);
        int g;
        g = exp_grant(d);
        check_eq($sformatf("d%0d m_cen", d), 32'(mcen[d]), 32'(g >= 0));
        if (g >= 0) begin
            check_eq($sformatf("d%0d m_addr", d), maddr[d], addr[d][g]);
            check_eq($sformatf("d%0d m_wdata", d), mwdata[d], wdata[d][g]);
            check_eq($sformatf("d%0d m_wen_strb", d), {27'd0, mwen[d], mstrb[d]},
                     {27'd0, wen[d][g], strb[d][g]});
        end
        check_eq($sformatf("d%0d arb_owner", d), 32'(own[d]),
                 32'((g >= 0) ? g : last_acc[d]));
        for (int n = 0; n < 2; n++) begin
            check_eq($sformatf("d%0d r%0d_stall", d, n), 32'(st[d][n]),
                     32'(cen[d][n] && !(g == n && !m_stall[d])));
            check_eq($sformatf("d%0d r%0d_error", d, n), 32'(er[d][n]),
                     32'(m_error[d] && resp_pend[d] && resp_who[d] == n));
            check_eq($sformatf("d%0d r%0d_rdata", d, n), rd[d][n], m_rdata[d]);
            st_prev[d][n] = st[d][n];
        end
    endtask

    task automatic model_step(int d);
        int g;
        bit acc;
        g   = exp_grant(d);
        acc = (g >= 0) && !m_stall[d];
        if (acc) begin
            if (g == last_acc[d] && cen[d][1-g])
                streak[d] = (streak[d] + 1 > mb(d) - 1) ? mb(d) - 1 : streak[d] + 1;
            else
                streak[d] = 0;
            last_acc[d]  = g;
            resp_pend[d] = 1'b1;
            resp_who[d]  = g;
            held[d]      = -1;
        end else begin
            resp_pend[d] = 1'b0;
            held[d]      = (g >= 0 && m_stall[d]) ? g : -1;
        end
    endtask

    task automatic check_reset_outputs(string tag);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s d%0d m_cen", tag, d), 32'(mcen[d]), 32'd0);
            check_eq($sformatf("%s d%0d arb_owner", tag, d), 32'(own[d]), 32'd0);
            for (int n = 0; n < 2; n++) begin
                check_eq($sformatf("%s d%0d r%0d_stall", tag, d, n), 32'(st[d][n]), 32'd0);
                check_eq($sformatf("%s d%0d r%0d_error", tag, d, n), 32'(er[d][n]), 32'd0);
            end
        end
    endtask

    task automatic run_cycles(int ncyc, int p_cen, int p_stall);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge g_clk);
            for (int d = 0; d < 2; d++) drive(d, p_cen, p_stall);
            #1;
            for (int d = 0; d < 2; d++) check_cycle(d);
            for (int d = 0; d < 2; d++) model_step(d);
        end
    endtask

    initial begin
        g_reset = 1'b1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 2; n++) begin
                wen[d][n] = 1'b0; strb[d][n] = 4'd0; addr[d][n] = '0; wdata[d][n] = '0;
            end
            m_stall[d] = 1'b0; m_error[d] = 1'b1; m_rdata[d] = '0;
        end
        #1;
        check_reset_outputs("por");
        @(negedge g_clk);
        g_reset = 1'b0;

        run_cycles(400, 60, 30);
        run_cycles(300, 95, 0);
        run_cycles(100, 90, 20);

        // Asynchronous reset mid-traffic must drop any pending response at once.
        @(negedge g_clk);
        model_reset();
        for (int d = 0; d < 2; d++) m_error[d] = 1'b1;
        g_reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge g_clk);
        g_reset = 1'b0;

        run_cycles(400, 80, 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
